// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank driver: command encodings, per-cell
// excitation codes ({j,k}) and the controller state enum.
package jk_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_TOGGLE = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    // The external cells clear on J-only and set on K-only.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b10;
    localparam logic [1:0] JK_SET  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/jk_bank_driver_if.sv
// Command, excitation and feedback signals between a host/JK bank and the
// bank driver.
interface jk_bank_driver_if
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   op_t              cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] q_fb;
   logic             busy;
   logic             done;
   logic             error;

   modport master (
      output cmd_valid, cmd_op, cmd_data, q_fb,
      input  cmd_ready, j, k, busy, done, error
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, q_fb,
      output cmd_ready, j, k, busy, done, error
   );
endinterface

// File: rtl/jk_excite.sv
// Per-cell JK excitation: toggle by mask, or set/clear a cell toward its
// target only when it differs.
module jk_excite
   import jk_pkg::*;
(
   input  logic q,
   input  logic target,
   input  logic tgl,
   output logic j,
   output logic k
);
   logic [1:0] code;

   always_comb begin
      if (tgl) begin
         code = target ? JK_TGL : JK_HOLD;
      end else if (q == target) begin
         code = JK_HOLD;
      end else begin
         code = target ? JK_SET : JK_CLR;
      end
   end

   assign {j, k} = code;
endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of external JK cells to a commanded value, verifies the
// feedback and re-drives mismatched bits a bounded number of times.
module jk_bank_driver
   import jk_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_RETRY = 3
) (
   input logic             clk,
   input logic             rst,
   jk_bank_driver_if.slave bus
);
   localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] expected_reg, expected_next;
   logic [WIDTH-1:0] j_reg, k_reg;
   logic [CNT_W-1:0] retry_cnt_reg;
   logic             error_reg;

   logic             ready;
   logic             accept;
   logic             match;
   logic [WIDTH-1:0] exc_target;
   logic             exc_tgl;
   logic [WIDTH-1:0] exc_j, exc_k;
   logic [WIDTH-1:0] drive_j, drive_k;

   assign ready  = (state_reg == ST_IDLE) && !rst;
   assign accept = bus.cmd_valid && ready;
   assign match  = (bus.q_fb == expected_reg);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept) state_next = ST_DRIVE;
         ST_DRIVE: state_next = ST_CHECK;
         ST_CHECK: begin
            if (match || (retry_cnt_reg == RETRY_LIMIT)) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_DRIVE;
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.cmd_ready = ready;
      bus.busy      = (state_reg != ST_IDLE);
      bus.done      = (state_reg == ST_DONE);
      bus.error     = error_reg;
      bus.j         = j_reg;
      bus.k         = k_reg;
   end

   always_comb begin
      expected_next = bus.q_fb;
      case (bus.cmd_op)
         OP_LOAD:   expected_next = bus.cmd_data;
         OP_TOGGLE: expected_next = bus.q_fb ^ bus.cmd_data;
         OP_CLEAR:  expected_next = '0;
         default:   expected_next = bus.q_fb;
      endcase
   end

   // In IDLE the excitation cells see the incoming command; otherwise they
   // compute the corrective set/clear toward the latched expectation.
   always_comb begin
      exc_target = expected_reg;
      exc_tgl    = 1'b0;
      if (state_reg == ST_IDLE) begin
         case (bus.cmd_op)
            OP_LOAD:   begin exc_target = bus.cmd_data; exc_tgl = 1'b0; end
            OP_TOGGLE: begin exc_target = bus.cmd_data; exc_tgl = 1'b1; end
            default:   begin exc_target = '0;           exc_tgl = 1'b1; end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         jk_excite u_excite (
            .q      (bus.q_fb[gi]),
            .target (exc_target[gi]),
            .tgl    (exc_tgl),
            .j      (exc_j[gi]),
            .k      (exc_k[gi])
         );
      end
   endgenerate

   // CLEAR asserts J on every cell regardless of its current value.
   always_comb begin
      drive_j = exc_j;
      drive_k = exc_k;
      if ((state_reg == ST_IDLE) && (bus.cmd_op == OP_CLEAR)) begin
         drive_j = '1;
         drive_k = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         j_reg         <= '0;
         k_reg         <= '0;
         expected_reg  <= '0;
         retry_cnt_reg <= '0;
         error_reg     <= 1'b0;
      end else begin
         if (state_next == ST_DRIVE) begin
            j_reg <= drive_j;
            k_reg <= drive_k;
         end else begin
            j_reg <= '0;
            k_reg <= '0;
         end

         if (accept) begin
            expected_reg  <= expected_next;
            retry_cnt_reg <= '0;
            error_reg     <= 1'b0;
         end else if ((state_reg == ST_CHECK) && !match) begin
            if (retry_cnt_reg == RETRY_LIMIT) begin
               error_reg <= 1'b1;
            end else begin
               retry_cnt_reg <= retry_cnt_reg + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: an 8-cell JK bank with fault injection feeds q_fb;
// directed and random commands are checked against a command-level model.
module tb_jk_bank_driver;
   import jk_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   jk_bank_driver_if #(.WIDTH(W)) bus ();

   jk_bank_driver #(.WIDTH(W), .MAX_RETRY(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // External JK bank: J-only clears, K-only sets, both toggles.
   logic [W-1:0] cell_q     = '0;
   logic [W-1:0] stuck_mask = '0;
   logic [W-1:0] flip_mask  = '0;
   logic [W-1:0] cell_next;

   assign cell_next = (cell_q & ~(bus.j | bus.k)) | (~bus.j & bus.k) | (bus.j & bus.k & ~cell_q);

   always @(posedge clk) cell_q <= (cell_next ^ flip_mask) & ~stuck_mask;

   assign bus.q_fb = cell_q;

   logic [W-1:0] j_hist [1:24];
   logic [W-1:0] k_hist [1:24];
   logic         err_hist [1:24];
   logic         busy_hist [1:24];
   int           done_cyc;
   int           nz;
   logic         err_done;
   logic [W-1:0] model_q = '0;

   task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_i(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model_target(input op_t op, input logic [W-1:0] d, input logic [W-1:0] q);
      case (op)
         OP_LOAD:   return d;
         OP_TOGGLE: return q ^ d;
         OP_CLEAR:  return '0;
         default:   return q;
      endcase
   endfunction

   task automatic model_first(input op_t op, input logic [W-1:0] d, input logic [W-1:0] q,
                              output logic [W-1:0] mj, output logic [W-1:0] mk);
      case (op)
         OP_LOAD:   begin mj = q & ~d; mk = ~q & d; end
         OP_TOGGLE: begin mj = d;      mk = d;      end
         OP_CLEAR:  begin mj = '1;     mk = '0;     end
         default:   begin mj = '0;     mk = '0;     end
      endcase
   endtask

   // Issue one command and record per-cycle J/K/done until done or timeout.
   task automatic run_cmd(input op_t op, input logic [W-1:0] data, input logic [W-1:0] flip, input bit hold);
      int waitc = 0;
      while (!bus.cmd_ready && waitc < 20) begin
         @(posedge clk); #1;
         waitc++;
      end
      check_i("ready_before_cmd", int'(bus.cmd_ready), 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      @(posedge clk); #1;
      done_cyc = 0;
      nz       = 0;
      err_done = 1'b0;
      for (int c = 1; c <= 24 && done_cyc == 0; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         j_hist[c]    = bus.j;
         k_hist[c]    = bus.k;
         err_hist[c]  = bus.error;
         busy_hist[c] = bus.busy;
         if ((bus.j | bus.k) != '0) nz++;
         if (bus.done) begin
            done_cyc = c;
            err_done = bus.error;
         end
         flip_mask = (c == 1) ? flip : '0;
         if (hold && c < 3) begin
            bus.cmd_data = W'($urandom);
         end else begin
            bus.cmd_valid = 1'b0;
         end
      end
      flip_mask = '0;
   endtask

   // Fault-free command with full model check.
   task automatic do_cmd(input op_t op, input logic [W-1:0] data, input bit hold);
      logic [W-1:0] mj, mk, tgt;
      model_first(op, data, model_q, mj, mk);
      tgt = model_target(op, data, model_q);
      run_cmd(op, data, '0, hold);
      $display("cmd op=%0d data=0x%02h q0=0x%02h j1=0x%02h k1=0x%02h done_cyc=%0d", op, data, model_q,
               j_hist[1], k_hist[1], done_cyc);
      check_w("first_j", j_hist[1], mj);
      check_w("first_k", k_hist[1], mk);
      check_i("busy_in_drive", int'(busy_hist[1]), 1);
      check_i("err_cleared_on_accept", int'(err_hist[1]), 0);
      check_w("check_cycle_jk", j_hist[2] | k_hist[2], '0);
      check_i("done_cycle", done_cyc, 3);
      check_i("error_at_done", int'(err_done), 0);
      check_w("q_after_cmd", bus.q_fb, tgt);
      @(posedge clk); #1;
      check_i("idle_after_done", int'(bus.busy), 0);
      check_i("ready_after_done", int'(bus.cmd_ready), 1);
      model_q = tgt;
   endtask

   initial begin
      int seen_done;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_data  = '0;

      // Reset state
      #1;
      check_w("rst_j", bus.j, '0);
      check_w("rst_k", bus.k, '0);
      check_i("rst_done", int'(bus.done), 0);
      check_i("rst_error", int'(bus.error), 0);
      check_i("rst_busy", int'(bus.busy), 0);
      check_i("rst_ready", int'(bus.cmd_ready), 0);
      #6 rst = 1'b0;
      @(posedge clk); #1;
      check_i("ready_after_rst", int'(bus.cmd_ready), 1);

      // Directed LOAD, TOGGLE, CLEAR
      do_cmd(OP_LOAD, 8'hA5, 1'b0);
      do_cmd(OP_TOGGLE, 8'h0F, 1'b0);
      do_cmd(OP_CLEAR, 8'h3C, 1'b0);

      // Bit 0 stuck at 0: three corrective re-drives, then error
      stuck_mask = 8'h01;
      run_cmd(OP_LOAD, 8'h01, '0, 1'b0);
      $display("stuck load 0x01 done_cyc=%0d drives=%0d error=%0d", done_cyc, nz, err_done);
      check_w("stuck_first_k", k_hist[1], 8'h01);
      for (int r = 3; r <= 7; r += 2) begin
         check_w("stuck_retry_j", j_hist[r], 8'h00);
         check_w("stuck_retry_k", k_hist[r], 8'h01);
      end
      check_i("stuck_drives", nz, 4);
      check_i("stuck_done_cycle", done_cyc, 9);
      check_i("stuck_error", int'(err_done), 1);
      @(posedge clk); #1;
      check_i("error_sticky", int'(bus.error), 1);
      stuck_mask = '0;

      // Transient flip of bit 3 before the first check
      run_cmd(OP_LOAD, 8'hF0, 8'h08, 1'b0);
      $display("flip load 0xF0 done_cyc=%0d j3=0x%02h k3=0x%02h", done_cyc, j_hist[3], k_hist[3]);
      check_i("flip_err_cleared", int'(err_hist[1]), 0);
      check_w("flip_first_k", k_hist[1], 8'hF0);
      check_w("flip_retry_j", j_hist[3], 8'h08);
      check_w("flip_retry_k", k_hist[3], 8'h00);
      check_i("flip_drives", nz, 2);
      check_i("flip_done_cycle", done_cyc, 5);
      check_i("flip_error", int'(err_done), 0);
      check_w("flip_q", bus.q_fb, 8'hF0);
      @(posedge clk); #1;
      model_q = 8'hF0;

      // Reset during DRIVE aborts the command
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = 8'h3C;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check_w("abort_drive_j", bus.j, 8'hC0);
      check_w("abort_drive_k", bus.k, 8'h0C);
      rst = 1'b1;
      #1;
      $display("reset in drive j=0x%02h k=0x%02h busy=%0d", bus.j, bus.k, bus.busy);
      check_w("abort_j", bus.j, '0);
      check_w("abort_k", bus.k, '0);
      check_i("abort_busy", int'(bus.busy), 0);
      check_i("abort_ready", int'(bus.cmd_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_i("abort_ready_after", int'(bus.cmd_ready), 1);
      seen_done = 0;
      for (int c = 0; c < 4; c++) begin
         if (bus.done || bus.busy) seen_done++;
         @(posedge clk); #1;
      end
      check_i("abort_no_done", seen_done, 0);
      check_w("abort_q", bus.q_fb, model_q);

      // cmd_valid held with changing data while busy: one command only
      do_cmd(OP_LOAD, 8'h5A, 1'b1);
      check_w("hold_single_q", bus.q_fb, 8'h5A);

      // Random commands
      for (int n = 0; n < 20; n++) begin
         do_cmd(op_t'(2'($urandom_range(0, 3))), W'($urandom), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
